// File: rtl/motoro3_pwm_ramp_scheduler.sv
// Soft-start/stop scheduler stepping plLen toward a target every N PWM periods; optional MOTORO3_RAMP_MINLEN_EN adds a minimum non-zero pulse.
// All outputs registered: plLen moves 1 clk after a qualifying m3cntLast1 tick; no backpressure, commands are one-cycle pulses.
module motoro3_pwm_ramp_scheduler #(
  parameter int LEN_W = 16,
  parameter int DIV_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [LEN_W-1:0] targetLen_i,
  input  logic [LEN_W-1:0] rampStep_i,
  input  logic [DIV_W-1:0] rampDiv_i,
`ifdef MOTORO3_RAMP_MINLEN_EN
  input  logic [LEN_W-1:0] minLen_i,
`endif
  input  logic             m3cntLast1_i,
  output logic [LEN_W-1:0] plLen_o,
  output logic             ramping_o,
  output logic             atTarget_o,
  output logic             done_o,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RAMP     = 2'd1,
    HOLD     = 2'd2,
    STOPPING = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] plLen_q, plLen_d;
  logic [LEN_W-1:0] tgt_q, tgt_d;
  logic [DIV_W-1:0] divCnt_q, divCnt_d;
  logic             ramping_q, ramping_d;
  logic             atTarget_q, atTarget_d;
  logic             done_q, done_d;

  logic [DIV_W-1:0] divMax;
  logic [LEN_W:0]   stepSz;
  logic [LEN_W:0]   cur, tg, nxt;
  logic [LEN_W-1:0] newTgt;
  logic             active, update;

  always_comb begin
    divMax = (rampDiv_i == '0) ? DIV_W'(1) : rampDiv_i;
    stepSz = {1'b0, ((rampStep_i == '0) ? LEN_W'(1) : rampStep_i)};
    active = (state_q == RAMP) || (state_q == STOPPING);
    update = m3cntLast1_i && active && (divCnt_q == divMax - DIV_W'(1));
`ifdef MOTORO3_RAMP_MINLEN_EN
    newTgt = (targetLen_i < minLen_i) ? '0 : targetLen_i;
`else
    newTgt = targetLen_i;
`endif

    state_d  = state_q;
    tgt_d    = tgt_q;
    plLen_d  = plLen_q;
    divCnt_d = divCnt_q;
    done_d   = 1'b0;
    cur      = '0;
    tg       = '0;
    nxt      = '0;

    // Commands first; a simultaneous update then steps toward the new target.
    case (state_q)
      IDLE: begin
        if (start_i && !stop_i) begin
          tgt_d = newTgt;
          if (newTgt != '0) state_d = RAMP;
        end
      end
      RAMP, HOLD: begin
        if (stop_i) begin
          state_d = STOPPING;
          tgt_d   = '0;
        end else if (start_i) begin
          tgt_d = newTgt;
          if (state_q == HOLD && newTgt != tgt_q) state_d = RAMP;
        end
      end
      default: ;
    endcase

    if (m3cntLast1_i) begin
      if (update)      divCnt_d = '0;
      else if (active) divCnt_d = divCnt_q + DIV_W'(1);
      else             divCnt_d = '0;
    end

    if (update) begin
      cur = {1'b0, plLen_q};
      tg  = {1'b0, tgt_d};
      if (tg >= cur) nxt = (tg - cur <= stepSz) ? tg : cur + stepSz;
      else           nxt = (cur - tg <= stepSz) ? tg : cur - stepSz;
`ifdef MOTORO3_RAMP_MINLEN_EN
      // Values the drivers cannot pass snap up to minLen or down to zero.
      if (nxt != '0 && nxt < {1'b0, minLen_i}) begin
        if (tg > cur) nxt = (tg < {1'b0, minLen_i}) ? tg : {1'b0, minLen_i};
        else          nxt = '0;
      end
`endif
      plLen_d = nxt[LEN_W-1:0];
      if (nxt[LEN_W-1:0] == tgt_d) begin
        if (state_d == STOPPING) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = HOLD;
        end
      end
    end

    ramping_d  = (state_d == RAMP) || (state_d == STOPPING);
    atTarget_d = (state_d == HOLD);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      plLen_q    <= '0;
      tgt_q      <= '0;
      divCnt_q   <= '0;
      ramping_q  <= 1'b0;
      atTarget_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      plLen_q    <= plLen_d;
      tgt_q      <= tgt_d;
      divCnt_q   <= divCnt_d;
      ramping_q  <= ramping_d;
      atTarget_q <= atTarget_d;
      done_q     <= done_d;
    end
  end

  assign plLen_o    = plLen_q;
  assign ramping_o  = ramping_q;
  assign atTarget_o = atTarget_q;
  assign done_o     = done_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_motoro3_pwm_ramp_scheduler.sv
// Bench for motoro3_pwm_ramp_scheduler: directed vector table, hand-written corner sequences, then random stimulus vs a behavioural model.
module tb_motoro3_pwm_ramp_scheduler;

  logic        clk, rst, start, stop, tick;
  logic [15:0] tlen, step, minLen;
  logic [7:0]  div;
  logic [15:0] plLen;
  logic        ramping, atTarget, done;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  // Behavioural reference state, kept as plain integers.
  int m_state, m_pl, m_tgt, m_div;
  bit m_done;

  typedef struct {
    int gap;
    bit st, sp;
    int tl, stp, dv;
    bit tk;
    int e_pl, e_state;
    bit e_done;
  } vec_t;
  vec_t vq[$];

  motoro3_pwm_ramp_scheduler dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .stop_i       (stop),
    .targetLen_i  (tlen),
    .rampStep_i   (step),
    .rampDiv_i    (div),
`ifdef MOTORO3_RAMP_MINLEN_EN
    .minLen_i     (minLen),
`endif
    .m3cntLast1_i (tick),
    .plLen_o      (plLen),
    .ramping_o    (ramping),
    .atTarget_o   (atTarget),
    .done_o       (done),
    .state_o      (state)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(int gap, bit st, bit sp, int tl, int stp, int dv, bit tk,
                              int e_pl, int e_state, bit e_done);
    vec_t v;
    v.gap = gap; v.st = st; v.sp = sp; v.tl = tl; v.stp = stp; v.dv = dv; v.tk = tk;
    v.e_pl = e_pl; v.e_state = e_state; v.e_done = e_done;
    return v;
  endfunction

  task automatic model_reset();
    m_state = 0; m_pl = 0; m_tgt = 0; m_div = 0; m_done = 0;
  endtask

  // One clock of the scheduler's rules applied to the currently driven inputs.
  task automatic model_clock();
    int s, d, ns, nt, np, ml, tl;
    bit act, upd;
    s  = (step == 0) ? 1 : int'(step);
    d  = (div == 0) ? 1 : int'(div);
    ml = int'(minLen);
    tl = (int'(tlen) < ml) ? 0 : int'(tlen);
    act = (m_state == 1) || (m_state == 3);
    upd = tick && act && (m_div == d - 1);
    ns = m_state; nt = m_tgt; np = m_pl;
    m_done = 0;
    if (m_state == 0) begin
      if (start && !stop) begin
        nt = tl;
        if (nt != 0) ns = 1;
      end
    end else if (m_state == 1 || m_state == 2) begin
      if (stop) begin
        ns = 3; nt = 0;
      end else if (start) begin
        nt = tl;
        if (m_state == 2 && nt != m_tgt) ns = 1;
      end
    end
    if (tick) m_div = upd ? 0 : (act ? (m_div + 1) % 256 : 0);
    if (upd) begin
      if (nt > m_pl) np = (m_pl + s < nt) ? m_pl + s : nt;
      else           np = (m_pl - s > nt) ? m_pl - s : nt;
      if (np > 0 && np < ml) np = (nt > m_pl) ? ((ml < nt) ? ml : nt) : 0;
      if (np == nt) begin
        if (ns == 3) begin ns = 0; m_done = 1; end
        else ns = 2;
      end
    end
    m_state = ns; m_tgt = nt; m_pl = np;
  endtask

  task automatic cmp_model(input string tag);
    check({tag, ".plLen"},    int'(plLen),    m_pl);
    check({tag, ".state"},    int'(state),    m_state);
    check({tag, ".ramping"},  int'(ramping),  int'(m_state == 1 || m_state == 3));
    check({tag, ".atTarget"}, int'(atTarget), int'(m_state == 2));
    check({tag, ".done"},     int'(done),     int'(m_done));
  endtask

  // Inputs are set just after a negedge; the posedge applies them; outputs sampled at the next negedge.
  task automatic clk_cycle(input string tag);
    model_clock();
    @(negedge clk);
    cmp_model(tag);
    start = 0; stop = 0; tick = 0;
  endtask

  task automatic do_reset();
    rst = 1; start = 0; stop = 0; tick = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    rst = 1; start = 0; stop = 0; tick = 0;
    tlen = 0; step = 0; div = 0; minLen = 0;
    model_reset();
    #20;
    check("async_rst.plLen", int'(plLen), 0);
    check("async_rst.state", int'(state), 0);
    do_reset();
    @(negedge clk);
    check("reset.plLen", int'(plLen), 0);
    check("reset.state", int'(state), 0);
    check("reset.ramping", int'(ramping), 0);
    check("reset.atTarget", int'(atTarget), 0);
    check("reset.done", int'(done), 0);

    // Ramp up, retarget down from HOLD, stop mid-ramp, divider, step/div zero.
    vq.push_back(mk(0,1,0,100,30,1,0,  0,1,0));
    vq.push_back(mk(9,0,0,100,30,1,1, 30,1,0));
    vq.push_back(mk(9,0,0,100,30,1,1, 60,1,0));
    vq.push_back(mk(9,0,0,100,30,1,1, 90,1,0));
    vq.push_back(mk(9,0,0,100,30,1,1,100,2,0));
    vq.push_back(mk(2,1,0, 40,25,1,0,100,1,0));
    vq.push_back(mk(2,0,0, 40,25,1,1, 75,1,0));
    vq.push_back(mk(2,0,0, 40,25,1,1, 50,1,0));
    vq.push_back(mk(2,0,0, 40,25,1,1, 40,2,0));
    vq.push_back(mk(2,1,0,100,20,1,0, 40,1,0));
    vq.push_back(mk(2,0,0,100,20,1,1, 60,1,0));
    vq.push_back(mk(2,0,1,100,25,1,0, 60,3,0));
    vq.push_back(mk(2,0,0,100,25,1,1, 35,3,0));
    vq.push_back(mk(2,1,0, 90,25,1,0, 35,3,0));
    vq.push_back(mk(2,0,0, 90,25,1,1, 10,3,0));
    vq.push_back(mk(2,0,0, 90,25,1,1,  0,0,1));
    vq.push_back(mk(0,0,0, 90,25,1,0,  0,0,0));
    vq.push_back(mk(2,1,0, 20,10,3,0,  0,1,0));
    vq.push_back(mk(2,0,0, 20,10,3,1,  0,1,0));
    vq.push_back(mk(2,0,0, 20,10,3,1,  0,1,0));
    vq.push_back(mk(2,0,0, 20,10,3,1, 10,1,0));
    vq.push_back(mk(2,0,0, 20,10,3,1, 10,1,0));
    vq.push_back(mk(2,0,0, 20,10,3,1, 10,1,0));
    vq.push_back(mk(2,0,0, 20,10,3,1, 20,2,0));
    vq.push_back(mk(2,0,0, 20,10,3,1, 20,2,0));
    vq.push_back(mk(2,0,0, 20,10,3,1, 20,2,0));
    vq.push_back(mk(2,1,0, 40,10,3,0, 20,1,0));
    vq.push_back(mk(2,0,0, 40,10,3,1, 20,1,0));
    vq.push_back(mk(2,0,0, 40,10,3,1, 20,1,0));
    vq.push_back(mk(2,0,0, 40,10,3,1, 30,1,0));
    vq.push_back(mk(2,1,1, 90,10,3,0, 30,3,0));
    vq.push_back(mk(2,0,0, 90,10,1,1, 20,3,0));
    vq.push_back(mk(2,0,0, 90,10,1,1, 10,3,0));
    vq.push_back(mk(2,0,0, 90,10,1,1,  0,0,1));
    vq.push_back(mk(2,1,0,  0,10,1,0,  0,0,0));
    vq.push_back(mk(2,0,0,  0,10,1,1,  0,0,0));
    vq.push_back(mk(2,1,0,  3, 0,0,0,  0,1,0));
    vq.push_back(mk(2,0,0,  3, 0,0,1,  1,1,0));
    vq.push_back(mk(0,0,0,  3, 0,0,1,  2,1,0));
    vq.push_back(mk(0,0,0,  3, 0,0,1,  3,2,0));
    vq.push_back(mk(2,1,0,  3, 0,0,0,  3,2,0));
    vq.push_back(mk(2,0,1,  3, 0,0,0,  3,3,0));
    vq.push_back(mk(0,0,0,  3, 0,0,1,  2,3,0));
    vq.push_back(mk(0,0,0,  3, 0,0,1,  1,3,0));
    vq.push_back(mk(0,0,0,  3, 0,0,1,  0,0,1));

    for (int i = 0; i < vq.size(); i++) begin
      for (int g = 0; g < vq[i].gap; g++) clk_cycle("gap");
      start = vq[i].st; stop = vq[i].sp; tick = vq[i].tk;
      tlen = 16'(vq[i].tl); step = 16'(vq[i].stp); div = 8'(vq[i].dv);
      clk_cycle("vec_model");
      check($sformatf("vec%0d.plLen", i), int'(plLen), vq[i].e_pl);
      check($sformatf("vec%0d.state", i), int'(state), vq[i].e_state);
      check($sformatf("vec%0d.done", i),  int'(done),  int'(vq[i].e_done));
    end

    // Reset mid-ramp: outputs clear asynchronously and no done pulse follows.
    start = 1; tlen = 50; step = 5; div = 1;
    clk_cycle("rst_seq");
    tick = 1; clk_cycle("rst_seq");
    tick = 1; clk_cycle("rst_seq");
    check("rst_seq.pre_plLen", int'(plLen), 10);
    #10 rst = 1;
    #1;
    check("rst_mid.plLen", int'(plLen), 0);
    check("rst_mid.state", int'(state), 0);
    check("rst_mid.ramping", int'(ramping), 0);
    check("rst_mid.done", int'(done), 0);
    model_reset();
    @(negedge clk);
    check("rst_hold.done", int'(done), 0);
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      tick = 1;
      clk_cycle("rst_after");
      check("rst_after.done", int'(done), 0);
    end

`ifdef MOTORO3_RAMP_MINLEN_EN
    minLen = 32; step = 8; div = 1; tlen = 50;
    start = 1; clk_cycle("minlen");
    tick = 1; clk_cycle("minlen"); check("minlen.up1", int'(plLen), 32);
    tick = 1; clk_cycle("minlen"); check("minlen.up2", int'(plLen), 40);
    tick = 1; clk_cycle("minlen"); check("minlen.up3", int'(plLen), 48);
    tick = 1; clk_cycle("minlen"); check("minlen.up4", int'(plLen), 50);
    check("minlen.hold", int'(state), 2);
    stop = 1; clk_cycle("minlen");
    tick = 1; clk_cycle("minlen"); check("minlen.dn1", int'(plLen), 42);
    tick = 1; clk_cycle("minlen"); check("minlen.dn2", int'(plLen), 34);
    tick = 1; clk_cycle("minlen"); check("minlen.dn3", int'(plLen), 0);
    check("minlen.done", int'(done), 1);
    tlen = 20; start = 1; clk_cycle("minlen");
    check("minlen.small_tgt", int'(state), 0);
    minLen = 0;
`endif

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 9) == 0);
      stop  = ($urandom_range(0, 19) == 0);
      tick  = ($urandom_range(0, 3) == 0);
      tlen  = 16'($urandom_range(0, 200));
      if (start) begin
        step = 16'($urandom_range(0, 40));
        div  = 8'($urandom_range(0, 3));
      end
      clk_cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
